vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colour bars, checker, gradient and bouncing box,
// with a two-stage pipeline and matching sync delay. Mode advances only at frame start.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned BOX_SIZE = 64
) (
    input  logic        VGA_CLK,
    input  logic        RSTn,
    input  logic        HS_in,
    input  logic        VS_in,
    input  logic        valid_in,
    input  logic [10:0] X,
    input  logic [10:0] Y,
    input  logic        mode_next,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [1:0]  mode
);

    localparam logic [10:0] XLim = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] YLim = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Box  = 11'(BOX_SIZE);

    logic [10:0] x1_q, y1_q;
    logic        valid1_q, hs1_q, vs1_q, hs2_q, vs2_q;
    logic [3:0]  r_q, g_q, b_q, r_d, g_d, b_d;
    logic [1:0]  mode_q, mode_d;
    logic        pending_q, pending_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [10:0] bx_q, bx_d, by_q, by_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic        vs_prev_q;
    logic        frame_ev;
    logic [2:0]  bar;
    logic        in_box;

    assign frame_ev = vs_prev_q & ~VS_in;

    always_comb begin
        mode_d      = mode_q;
        pending_d   = pending_q | mode_next;
        frame_cnt_d = frame_cnt_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        if (frame_ev) begin
            // A request arriving on the event edge itself counts toward this frame.
            if (pending_q | mode_next) mode_d = mode_q + 2'd1;
            pending_d   = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (dx_q && bx_q == XLim) begin
                bx_d = XLim - 11'd1;
                dx_d = 1'b0;
            end else if (!dx_q && bx_q == 11'd0) begin
                bx_d = 11'd1;
                dx_d = 1'b1;
            end else begin
                bx_d = dx_q ? bx_q + 11'd1 : bx_q - 11'd1;
            end
            if (dy_q && by_q == YLim) begin
                by_d = YLim - 11'd1;
                dy_d = 1'b0;
            end else if (!dy_q && by_q == 11'd0) begin
                by_d = 11'd1;
                dy_d = 1'b1;
            end else begin
                by_d = dy_q ? by_q + 11'd1 : by_q - 11'd1;
            end
        end
    end

    always_comb begin
        if      (x1_q < 11'd100) bar = 3'd0;
        else if (x1_q < 11'd200) bar = 3'd1;
        else if (x1_q < 11'd300) bar = 3'd2;
        else if (x1_q < 11'd400) bar = 3'd3;
        else if (x1_q < 11'd500) bar = 3'd4;
        else if (x1_q < 11'd600) bar = 3'd5;
        else if (x1_q < 11'd700) bar = 3'd6;
        else                     bar = 3'd7;
        in_box = (x1_q >= bx_q) && (x1_q < bx_q + Box) &&
                 (y1_q >= by_q) && (y1_q < by_q + Box);
    end

    always_comb begin
        r_d = 4'h0;
        g_d = 4'h0;
        b_d = 4'h0;
        if (valid1_q) begin
            unique case (mode_q)
                2'd0: begin
                    // Bar order white..black maps onto inverted index bits.
                    r_d = {4{~bar[1]}};
                    g_d = {4{~bar[2]}};
                    b_d = {4{~bar[0]}};
                end
                2'd1: begin
                    r_d = {4{~(x1_q[5] ^ y1_q[5])}};
                    g_d = r_d;
                    b_d = r_d;
                end
                2'd2: begin
                    r_d = x1_q[9:6];
                    g_d = y1_q[9:6];
                    b_d = frame_cnt_q[3:0];
                end
                default: begin
                    r_d = {4{in_box}};
                    g_d = {4{in_box}};
                    b_d = 4'hF;
                end
            endcase
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RSTn) begin
            x1_q        <= 11'd0;
            y1_q        <= 11'd0;
            valid1_q    <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            r_q         <= 4'h0;
            g_q         <= 4'h0;
            b_q         <= 4'h0;
            mode_q      <= 2'd0;
            pending_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            bx_q        <= 11'd0;
            by_q        <= 11'd0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            vs_prev_q   <= 1'b1;
        end else begin
            x1_q        <= X;
            y1_q        <= Y;
            valid1_q    <= valid_in;
            hs1_q       <= HS_in;
            vs1_q       <= VS_in;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            vs_prev_q   <= VS_in;
        end
    end

    assign VGA_R  = r_q;
    assign VGA_G  = g_q;
    assign VGA_B  = b_q;
    assign VGA_HS = hs2_q;
    assign VGA_VS = vs2_q;
    assign mode   = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: pixel scoreboard, sync delay, mode stepping,
// box bounce and reset behaviour.
module tb_vga_pattern_gen;

    logic        VGA_CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        HS_in = 1'b1;
    logic        VS_in = 1'b1;
    logic        valid_in = 1'b0;
    logic [10:0] X = 11'd0;
    logic [10:0] Y = 11'd0;
    logic        mode_next = 1'b0;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;
    int ev = 0;
    logic [11:0] sb[$];
    logic [1:0]  sq[$];

    vga_pattern_gen dut (
        .VGA_CLK   (VGA_CLK),
        .RSTn      (RSTn),
        .HS_in     (HS_in),
        .VS_in     (VS_in),
        .valid_in  (valid_in),
        .X         (X),
        .Y         (Y),
        .mode_next (mode_next),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .VGA_HS    (VGA_HS),
        .VGA_VS    (VGA_VS),
        .mode      (mode)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic px(input string tag, input logic [10:0] x, input logic [10:0] y,
                      input logic v, input logic [11:0] exp);
        logic [11:0] e;
        @(negedge VGA_CLK);
        X = x;
        Y = y;
        valid_in = v;
        sb.push_back(exp);
        @(posedge VGA_CLK);
        @(posedge VGA_CLK);
        #1;
        e = sb.pop_front();
        chk(tag, {20'd0, VGA_R, VGA_G, VGA_B}, {20'd0, e});
    endtask

    task automatic frame(input logic pulse);
        @(negedge VGA_CLK);
        VS_in = 1'b0;
        mode_next = pulse;
        @(posedge VGA_CLK);
        ev++;
        @(negedge VGA_CLK);
        VS_in = 1'b1;
        mode_next = 1'b0;
        @(posedge VGA_CLK);
    endtask

    task automatic pulse_next();
        @(negedge VGA_CLK);
        mode_next = 1'b1;
        @(negedge VGA_CLK);
        mode_next = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge VGA_CLK);
        RSTn = 1'b0;
        @(posedge VGA_CLK);
        #1;
        ev = 0;
        @(negedge VGA_CLK);
        RSTn = 1'b1;
    endtask

    initial begin
        // Reset state
        @(posedge VGA_CLK);
        @(posedge VGA_CLK);
        #1;
        chk("rst_rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("rst_syncs", {30'd0, VGA_HS, VGA_VS}, 32'h3);
        chk("rst_mode", {30'd0, mode}, 32'h0);
        chk("rst_dir", {30'd0, dut.dx_q, dut.dy_q}, 32'h3);
        @(negedge VGA_CLK);
        RSTn = 1'b1;

        // Mode 0 colour bars
        px("bar_yellow", 11'd150, 11'd10, 1'b1, 12'hFF0);
        px("bar_black", 11'd799, 11'd10, 1'b1, 12'h000);
        px("bar_white", 11'd0, 11'd10, 1'b1, 12'hFFF);
        px("bar_cyan", 11'd250, 11'd10, 1'b1, 12'h0FF);
        px("bar_magenta", 11'd450, 11'd10, 1'b1, 12'hF0F);
        px("bar_blue", 11'd699, 11'd10, 1'b1, 12'h00F);
        px("blank", 11'd0, 11'd0, 1'b0, 12'h000);

        // Sync delay: random HS/VS stream reproduced two cycles later
        for (int i = 0; i < 20; i++) begin
            @(negedge VGA_CLK);
            HS_in = 1'($urandom);
            VS_in = 1'($urandom);
            sq.push_back({HS_in, VS_in});
            @(posedge VGA_CLK);
            #1;
            if (sq.size() >= 2) chk("sync_delay", {30'd0, VGA_HS, VGA_VS}, {30'd0, sq.pop_front()});
        end
        sq.delete();
        @(negedge VGA_CLK);
        HS_in = 1'b1;
        VS_in = 1'b1;
        do_reset();

        // Several mode_next pulses in one frame advance by exactly one
        pulse_next();
        pulse_next();
        pulse_next();
        #1;
        chk("mode_hold", {30'd0, mode}, 32'h0);
        chk("pending_set", {31'd0, dut.pending_q}, 32'h1);
        frame(1'b0);
        chk("mode_adv", {30'd0, mode}, 32'h1);
        chk("pending_clr", {31'd0, dut.pending_q}, 32'h0);
        px("chk_32_0", 11'd32, 11'd0, 1'b1, 12'h000);
        px("chk_32_32", 11'd32, 11'd32, 1'b1, 12'hFFF);
        px("chk_0_0", 11'd0, 11'd0, 1'b1, 12'hFFF);
        frame(1'b0);
        chk("mode_no_adv", {30'd0, mode}, 32'h1);

        // Mode 2 with frame_cnt = 5, then mid-line reset
        do_reset();
        frame(1'b1);
        frame(1'b1);
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        chk("mode2", {30'd0, mode}, 32'h2);
        chk("fcnt5", {24'd0, dut.frame_cnt_q}, 32'h5);
        px("grad", 11'd448, 11'd192, 1'b1, 12'h735);
        @(negedge VGA_CLK);
        HS_in = 1'b0;
        VS_in = 1'b1;
        @(posedge VGA_CLK);
        @(posedge VGA_CLK);
        #1;
        chk("hs_low", {31'd0, VGA_HS}, 32'h0);
        @(negedge VGA_CLK);
        RSTn = 1'b0;
        @(posedge VGA_CLK);
        #1;
        chk("mrst_rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("mrst_syncs", {30'd0, VGA_HS, VGA_VS}, 32'h3);
        chk("mrst_mode", {30'd0, mode}, 32'h0);
        chk("mrst_fcnt", {24'd0, dut.frame_cnt_q}, 32'h0);
        chk("mrst_box", {10'd0, dut.bx_q, dut.by_q}, 32'h0);
        @(negedge VGA_CLK);
        RSTn = 1'b1;
        HS_in = 1'b1;
        ev = 0;

        // mode_next coincident with frame event at mode 3 wraps to 0
        frame(1'b1);
        frame(1'b1);
        frame(1'b1);
        chk("mode3", {30'd0, mode}, 32'h3);
        frame(1'b1);
        chk("mode_wrap", {30'd0, mode}, 32'h0);
        chk("wrap_pending", {31'd0, dut.pending_q}, 32'h0);

        // Box bounce over 737 frame events from reset
        do_reset();
        frame(1'b1);
        frame(1'b1);
        frame(1'b1);
        while (ev < 536) frame(1'b0);
        chk("by_top", {21'd0, dut.by_q}, 32'd536);
        chk("dy_top", {31'd0, dut.dy_q}, 32'h1);
        frame(1'b0);
        chk("by_back", {21'd0, dut.by_q}, 32'd535);
        chk("dy_back", {31'd0, dut.dy_q}, 32'h0);
        while (ev < 736) frame(1'b0);
        chk("bx_top", {21'd0, dut.bx_q}, 32'd736);
        chk("dx_top", {31'd0, dut.dx_q}, 32'h1);
        chk("by_736", {21'd0, dut.by_q}, 32'd336);
        px("box_corner", 11'd736, 11'd336, 1'b1, 12'hFFF);
        px("box_far", 11'd799, 11'd399, 1'b1, 12'hFFF);
        px("box_right", 11'd800, 11'd336, 1'b1, 12'h00F);
        px("box_left", 11'd735, 11'd336, 1'b1, 12'h00F);
        px("box_below", 11'd736, 11'd400, 1'b1, 12'h00F);
        frame(1'b0);
        chk("bx_back", {21'd0, dut.bx_q}, 32'd735);
        chk("dx_back", {31'd0, dut.dx_q}, 32'h0);
        chk("by_737", {21'd0, dut.by_q}, 32'd335);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
